// File: rtl/debounce_ctrl.sv
// Debounce controller: per-channel synchronizer + STABLE/PENDING FSM sharing one prescaler tick.
// Optional sticky event flags (event_o / clear_i) are enabled by defining DEBOUNCE_CTRL_STICKY_EN.
module debounce_ctrl #(
  parameter int unsigned NumInputs    = 4,
  parameter int unsigned SyncStages   = 2,
  parameter logic        InitialValue = 1'b1,
  parameter int unsigned TickDiv      = 12000,
  parameter int unsigned StableTicks  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic [NumInputs-1:0] raw_i,
  output logic [NumInputs-1:0] level_o,
  output logic [NumInputs-1:0] rise_o,
  output logic [NumInputs-1:0] fall_o,
`ifdef DEBOUNCE_CTRL_STICKY_EN
  input  logic [NumInputs-1:0] clear_i,
  output logic [NumInputs-1:0] event_o,
`endif
  output logic                 tick_o
);

  localparam int unsigned PrescW = $clog2(TickDiv);
  localparam int unsigned CntW   = $clog2(StableTicks + 1);

  localparam logic [PrescW-1:0] PrescLast = PrescW'(TickDiv - 1);
  localparam logic [CntW-1:0]   CntAccept = CntW'(StableTicks - 1);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_e;

  logic [PrescW-1:0] r_presc;
  logic              r_tick;
  logic              w_tick;

  // Channels consume the combinational tick so enable_i freezes counting in
  // the same cycle; tick_o is a registered copy for observation only.
  assign w_tick = enable_i && (r_presc == PrescLast);
  assign tick_o = r_tick;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_tick <= w_tick;
      if (w_tick) begin
        r_presc <= '0;
      end else if (enable_i) begin
        r_presc <= r_presc + PrescW'(1);
      end
    end
  end

  for (genvar n = 0; n < NumInputs; n++) begin : g_ch
    logic [SyncStages-1:0] r_sync;
    logic                  w_sync;
    state_e                r_state;
    state_e                w_state_nxt;
    logic [CntW-1:0]       r_cnt;
    logic [CntW-1:0]       w_cnt_nxt;
    logic                  r_level;
    logic                  r_rise;
    logic                  r_fall;
    logic                  w_accept;
    logic                  w_rise_nxt;
    logic                  w_fall_nxt;

    // Synchronizer chain; only its last stage feeds the FSM.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_sync <= {SyncStages{InitialValue}};
      end else begin
        r_sync <= {r_sync[SyncStages-2:0], raw_i[n]};
      end
    end

    assign w_sync = r_sync[SyncStages-1];

    // State register, including the registered level and edge pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_state <= ST_STABLE;
        r_cnt   <= '0;
        r_level <= InitialValue;
        r_rise  <= 1'b0;
        r_fall  <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_level <= r_level ^ w_accept;
        r_rise  <= w_rise_nxt;
        r_fall  <= w_fall_nxt;
      end
    end

    // Next-state logic. A revert to the current level always wins, even on an
    // accepting tick or while enable_i is low.
    always_comb begin
      // NOTE: default assignments first keep this combinational process
      // latch-free on every path through the case.
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
        ST_STABLE: begin
          if (w_sync != r_level) begin
            w_state_nxt = ST_PENDING;
            w_cnt_nxt   = '0;
          end
        end
        ST_PENDING: begin
          if (w_sync == r_level) begin
            w_state_nxt = ST_STABLE;
            w_cnt_nxt   = '0;
          end else if (w_tick) begin
            if (r_cnt == CntAccept) begin
              w_state_nxt = ST_STABLE;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt + CntW'(1);
            end
          end
        end
        default: begin
          w_state_nxt = ST_STABLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    // Output decode: acceptance toggles the level and picks exactly one pulse.
    always_comb begin
      w_accept = 1'b0;
      if ((r_state == ST_PENDING) && (w_sync != r_level) && w_tick
          && (r_cnt == CntAccept)) begin
        w_accept = 1'b1;
      end
      w_rise_nxt = w_accept & ~r_level;
      w_fall_nxt = w_accept & r_level;
    end

    assign level_o[n] = r_level;
    assign rise_o[n]  = r_rise;
    assign fall_o[n]  = r_fall;

`ifdef DEBOUNCE_CTRL_STICKY_EN
    logic r_event;

    // Set has priority over clear so an edge coinciding with a clear is kept.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_event <= 1'b0;
      end else if (r_rise || r_fall) begin
        r_event <= 1'b1;
      end else if (clear_i[n]) begin
        r_event <= 1'b0;
      end
    end

    assign event_o[n] = r_event;
`endif
  end

endmodule

// File: tb/tb_debounce_ctrl.sv
// Scoreboard bench for debounce_ctrl (TickDiv=4, StableTicks=3, SyncStages=2, NumInputs=4).
// Stimulus pushes expected edge events; a negedge monitor pops and compares on every pulse.
module tb_debounce_ctrl;
  localparam int N = 4;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         enable_i;
  logic [N-1:0] raw_i;
  logic [N-1:0] level_o;
  logic [N-1:0] rise_o;
  logic [N-1:0] fall_o;
  logic         tick_o;
`ifdef DEBOUNCE_CTRL_STICKY_EN
  logic [N-1:0] clear_i;
  logic [N-1:0] event_o;
`endif

  debounce_ctrl #(
    .NumInputs   (N),
    .SyncStages  (2),
    .InitialValue(1'b1),
    .TickDiv     (4),
    .StableTicks (3)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .enable_i(enable_i),
    .raw_i   (raw_i),
    .level_o (level_o),
    .rise_o  (rise_o),
    .fall_o  (fall_o),
`ifdef DEBOUNCE_CTRL_STICKY_EN
    .clear_i (clear_i),
    .event_o (event_o),
`endif
    .tick_o  (tick_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    string        name;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic [N-1:0] level;
    int           lo;
    int           hi;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_evt(input string name, input logic [N-1:0] rise, input logic [N-1:0] fall,
                            input logic [N-1:0] level, input int lo, input int hi);
    exp_t e;
    e.name = name; e.rise = rise; e.fall = fall; e.level = level; e.lo = lo; e.hi = hi;
    sb.push_back(e);
  endtask

  // Advance n clock edges and settle 1 time unit past the last edge.
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Monitor: any pulse must match the oldest expected event.
  always @(negedge clk_i) begin
    if ((rise_o | fall_o) != '0) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_pulse: rise=%h fall=%h at cycle %0d, no event expected",
                 rise_o, fall_o, cyc);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_rise"}, 32'(rise_o), 32'(mon_e.rise));
        check({mon_e.name, "_fall"}, 32'(fall_o), 32'(mon_e.fall));
        check({mon_e.name, "_level"}, 32'(level_o), 32'(mon_e.level));
        n_checks++;
        if (cyc < mon_e.lo || cyc > mon_e.hi) begin
          n_errors++;
          $display("FAIL %s_latency: pulse at cycle %0d, expected within %0d..%0d",
                   mon_e.name, cyc, mon_e.lo, mon_e.hi);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int e;
    bit seen;
    rst_i    = 1'b1;
    enable_i = 1'b1;
    raw_i    = 4'hF;
`ifdef DEBOUNCE_CTRL_STICKY_EN
    clear_i  = '0;
`endif

    // 1. Reset values, then tick every 4th cycle after release.
    for (int i = 0; i < 5; i++) begin
      wait_cyc(1);
      check("rst_level", 32'(level_o), 32'hF);
      check("rst_pulses", 32'({rise_o, fall_o, tick_o}), 32'h0);
    end
    rst_i = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      wait_cyc(1);
      check($sformatf("tick_%0d", k), 32'(tick_o), 32'((k % 4) == 0));
    end

    // 2. Accepted fall on channel 0, then its rise back.
    e = cyc; raw_i = 4'hE;
    expect_evt("fall0", 4'h0, 4'h1, 4'hE, e + 12, e + 15);
    wait_cyc(30);
    check("fall0_level_held", 32'(level_o), 32'hE);
    e = cyc; raw_i = 4'hF;
    expect_evt("rise0", 4'h1, 4'h0, 4'hF, e + 12, e + 15);
    wait_cyc(30);

    // 3. Six-cycle glitch on channel 1 is rejected.
    raw_i = 4'hD;
    wait_cyc(6);
    raw_i = 4'hF;
    wait_cyc(30);
    check("glitch_level", 32'(level_o), 32'hF);

    // 4. All channels toggle together.
    e = cyc; raw_i = 4'h0;
    expect_evt("fall_all", 4'h0, 4'hF, 4'h0, e + 12, e + 15);
    wait_cyc(40);
    check("fall_all_level", 32'(level_o), 32'h0);
    e = cyc; raw_i = 4'hF;
    expect_evt("rise_all", 4'hF, 4'h0, 4'hF, e + 12, e + 15);
    wait_cyc(30);
    check("rise_all_level", 32'(level_o), 32'hF);

    // 5. Freeze with enable low, then release; then reset mid-PENDING.
    enable_i = 1'b0;
    raw_i    = 4'hB;
    wait_cyc(50);
    check("frozen_level", 32'(level_o), 32'hF);
    check("frozen_tick", 32'(tick_o), 32'h0);
    e = cyc; enable_i = 1'b1;
    expect_evt("fall2_unfreeze", 4'h0, 4'h4, 4'hB, e + 1, e + 12);
    wait_cyc(20);
    check("fall2_level", 32'(level_o), 32'hB);
    e = cyc; raw_i = 4'hF;
    expect_evt("rise2", 4'h4, 4'h0, 4'hF, e + 12, e + 15);
    wait_cyc(30);
    raw_i = 4'hB;
    wait_cyc(8);
    rst_i = 1'b1;
    raw_i = 4'hF;
    for (int i = 0; i < 3; i++) begin
      wait_cyc(1);
      check("midpend_rst_level", 32'(level_o), 32'hF);
      check("midpend_rst_pulses", 32'({rise_o, fall_o}), 32'h0);
    end
    rst_i = 1'b0;
    wait_cyc(30);
    check("post_rst_level", 32'(level_o), 32'hF);

`ifdef DEBOUNCE_CTRL_STICKY_EN
    // 6. Sticky event flag: set, hold, clear, and set-wins-over-clear.
    check("event_reset", 32'(event_o), 32'h0);
    e = cyc; raw_i = 4'h7;
    expect_evt("fall3", 4'h0, 4'h8, 4'h7, e + 12, e + 15);
    wait_cyc(30);
    check("event_set", 32'(event_o), 32'h8);
    wait_cyc(20);
    check("event_hold", 32'(event_o), 32'h8);
    clear_i = 4'h8;
    wait_cyc(1);
    clear_i = 4'h0;
    check("event_cleared", 32'(event_o), 32'h0);
    e = cyc; raw_i = 4'hF;
    expect_evt("rise3", 4'h8, 4'h0, 4'hF, e + 12, e + 15);
    seen = 1'b0;
    for (int i = 0; i < 25 && !seen; i++) begin
      @(negedge clk_i);
      if (rise_o[3]) seen = 1'b1;
    end
    check("rise3_seen", 32'(seen), 32'h1);
    if (seen) begin
      clear_i = 4'h8;
      @(posedge clk_i);
      #1;
      clear_i = 4'h0;
      check("event_set_wins", 32'(event_o), 32'h8);
    end
    wait_cyc(10);
`endif

    wait_cyc(5);
    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/debounce_ctrl.md
Name: debounce_ctrl

Overview:
Debounce controller for a bank of asynchronous pushbutton/switch inputs.
- Each input passes through a team synchronizer instance.
- A per-channel state machine accepts a new level only after it holds stable for a programmable number of ticks.
- All channels share one prescaler tick.
- Sits between board pins and user logic, e.g. the video-mode select buttons; emits clean levels plus single-cycle edge pulses.

Parameters:
NumInputs, 4, number of independent input channels (1..16)
SyncStages, 2, synchronizer depth per channel (>=2)
InitialValue, 1'b1, reset level of synchronizers and debounced outputs (pull-up buttons idle high)
TickDiv, 12000, clk_i cycles per debounce tick (1 ms at 12 MHz); >=2
StableTicks, 8, consecutive ticks a new level must persist before acceptance; >=1

Ports:
clk_i  input  1  system clock
rst_i  input  1  reset, asynchronous, active-high
enable_i  input  1  tick enable; low freezes prescaler and all pending counters
raw_i  input  NumInputs  asynchronous raw inputs
level_o  output  NumInputs  debounced level per channel
rise_o  output  NumInputs  1-cycle pulse when level_o goes 0->1
fall_o  output  NumInputs  1-cycle pulse when level_o goes 1->0
tick_o  output  1  1-cycle pulse on each shared debounce tick (observability)

Behaviour:
Interface and reset:
- Clock clk_i. Reset rst_i is asynchronous, active-high.
- During and after reset: level_o = {NumInputs{InitialValue}}; rise_o, fall_o, tick_o = 0; prescaler = 0; all channels in STABLE with counter = 0.

Synchronization:
- raw_i[n] feeds a synchronizer (SyncStages, InitialValue); its output is sync[n].
- No raw_i bit reaches any other logic.

Prescaler:
- Counter 0..TickDiv-1, width $clog2(TickDiv); advances only while enable_i = 1.
- tick asserts for the single cycle in which the counter = TickDiv-1 and enable_i = 1; the counter then wraps to 0.
- tick_o is that tick, registered-equivalent: no combinational path from enable_i.

Channel FSM (states STABLE, PENDING; counter cnt, width $clog2(StableTicks+1)):
- STABLE:
  - sync == level: stay.
  - sync != level: go to PENDING, cnt = 0.
- PENDING:
  - sync == level in any cycle: return to STABLE, cnt = 0 (glitch rejected, no pulse).
  - Otherwise, on each tick: cnt += 1.
  - On the tick where cnt reaches StableTicks: level toggles, matching rise_o/fall_o asserts for exactly that one cycle, go to STABLE, cnt = 0.
- Exactly one of rise_o/fall_o may be high per channel per cycle; never both.

Latency:
- Acceptance occurs between (StableTicks-1)*TickDiv+1 and StableTicks*TickDiv cycles after PENDING entry.
- PENDING entry is SyncStages+1 cycles after the raw edge.

Boundary conditions:
- Simultaneous events: channels are independent; several may toggle and pulse in the same cycle.
- Input reverts in the same cycle as the accepting tick: the revert wins; no toggle, return to STABLE.
- enable_i low: prescaler, cnt and state freeze; glitch rejection still active (a revert returns to STABLE).
- Reset mid-PENDING: immediate return to reset values; no pulse emitted.

Optional Feature:
DEBOUNCE_CTRL_STICKY_EN
- Defined: adds ports event_o (output, NumInputs) and clear_i (input, NumInputs).
  - event_o[n] sets on any rise_o[n] or fall_o[n].
  - It holds until a cycle with clear_i[n] = 1.
  - Set and clear in the same cycle: set wins.
  - event_o resets to 0.
- Not defined: ports and logic absent; all other behaviour identical.

Test Plan:
(Bench parameters TickDiv=4, StableTicks=3, SyncStages=2, NumInputs=4, InitialValue=1, enable_i=1 unless stated.)
1. Reset: hold rst_i 5 cycles, raw_i=4'hF → level_o=4'hF; rise_o, fall_o, tick_o = 0 during reset; tick_o pulses every 4th cycle after release.
2. Accepted fall: raw_i[0] 1→0, held 30 cycles → exactly one fall_o[0] pulse, 12..15 cycles after the edge; level_o[0]=0 from that cycle; no rise_o.
3. Glitch: raw_i[1] low for 6 cycles then high → no fall_o/rise_o on any channel; level_o stays 4'hF.
4. Simultaneous: raw_i 4'hF→4'h0 in one cycle, then back to 4'hF after 40 cycles → fall_o=4'hF in one common cycle; later rise_o=4'hF in one common cycle; level_o tracks.
5. Freeze and reset: raw_i[2]→0 with enable_i=0 for 50 cycles → no change. Re-enable → fall_o[2] within 12 cycles. Repeat, asserting rst_i mid-PENDING → level_o[2]=1, no pulse.
6. Sticky (macro defined): fall on channel 3 → event_o[3]=1 persists 20 cycles. clear_i[3] pulse → 0. clear_i[3] in the same cycle as a new edge → event_o[3] stays 1.
